store_run_tracker: RTL and testbench
====================================

STORE_RUN_TRACKER -- requirements
Module: store_run_tracker

Interface
REQ-001 SHALL have parameter MIN_RUN_BYTES, default 32: minimum run length in bytes for a run to be committed.
REQ-002 SHALL have parameter TIMEOUT, default 10: number of non-store ops a run survives without extension.
REQ-003 SHALL have ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous clear of all state.
- valid_i  in  1  issued-op qualifier.
- kind_i  in  2  op kind: 0 other, 1 store, 2 load, 3 JALR.
- size_i  in  3  store size in bytes.
- frame_i  in  1  store base register is sp or fp.
- addr_i  in  32  effective address.
- hit_i  in  1  range buffer reports addr_i inside a committed range (same cycle).
- en_crash_i  in  1  crash enable.
- wr_valid_o  out  1  commit entry valid.
- wr_ready_i  in  1  range buffer accepts entry.
- wr_start_o  out  32  committed run first address.
- wr_last_o  out  32  committed run last store address.
- active_o  out  1  a run is being tracked.
- drop_o  out  1  sticky: a qualifying run was lost.
- crash_o  out  1  one-cycle crash request.

Function
REQ-004 SHALL treat an op as a tracked store only when valid_i=1, kind_i=1, frame_i=0 and size_i is 1, 2 or 4; all other stores SHALL be ignored entirely.
REQ-005 Tracker FSM states SHALL be IDLE and TRACK, with registers start, last, last_size, count (16 bit, saturating at 0xFFFF) and timer (4 bit).
REQ-006 IDLE + tracked store: go to TRACK with start=last=addr_i, last_size=size_i, count=size_i, timer=TIMEOUT.
REQ-007 TRACK + tracked store with addr_i == last+last_size (32-bit modulo add) is an extension: last=addr_i, last_size=size_i, count+=size_i (saturating), timer=TIMEOUT, FSM stays in TRACK.
REQ-008 TRACK + non-adjacent tracked store SHALL close the run and, in the same cycle, seed a new run from addr_i per REQ-006; FSM stays in TRACK.
REQ-009 TRACK + valid non-store op: if timer != 0, decrement timer; if timer == 0, close the run and go to IDLE.
REQ-010 Invalid cycles (valid_i=0) SHALL change no state.
REQ-011 Closing a run with count >= MIN_RUN_BYTES SHALL be a commit; a shorter run SHALL be discarded silently.
REQ-012 Commit output SHALL be a one-entry holding register: wr_valid_o rises the cycle after the closing op, carrying wr_start_o=start and wr_last_o=last. The entry transfers on wr_valid_o && wr_ready_i.
REQ-013 wr_start_o and wr_last_o SHALL stay stable while wr_valid_o=1 and wr_ready_i=0.
REQ-014 A commit in the same cycle as a transfer SHALL load the register (wr_valid_o stays 1, no drop).
REQ-015 A commit while the register holds an untransferred entry SHALL discard the new run and set drop_o; the held entry SHALL be kept.
REQ-016 Valid load: armed = hit_i OR (active_o AND start <= addr_i <= last, unsigned); each valid load overwrites armed.
REQ-017 Valid JALR with armed=1 and en_crash_i=1 SHALL assert crash_o for exactly the next cycle; every valid JALR SHALL clear armed.
REQ-018 active_o SHALL equal (state == TRACK).
REQ-019 clear_i=1 SHALL, at the next edge, force IDLE, wr_valid_o=0, drop_o=0, armed=0 and crash_o=0, overriding any simultaneous input.

Reset
REQ-020 While rst_ni=0: state=IDLE; all registers 0; wr_valid_o, wr_start_o, wr_last_o, active_o, drop_o and crash_o all 0.
REQ-021 Reset mid-run or mid-handshake SHALL discard the run and any held entry with no transfer.

Verification
REQ-022 Nine 4-byte stores 0x1000..0x1020, then a store to 0x2000 -> next cycle wr_valid_o=1, wr_start_o=0x1000, wr_last_o=0x1020; active_o stays 1 with the new run at 0x2000.
REQ-023 Eight 4-byte stores from 0x1000 (count 32), then 11 valid "other" ops -> commit after the 11th op, active_o=0; with 7 stores (count 28) -> no wr_valid_o.
REQ-024 Two qualifying runs closed while wr_ready_i=0 -> first entry held stable, drop_o=1; wr_ready_i=1 for one cycle -> transfer, wr_valid_o=0.
REQ-025 Active run 0x1000..0x1020, load to 0x1010, JALR with en_crash_i=1 -> crash_o=1 for one cycle; load to 0x3000 (hit_i=0) before the JALR -> no crash.
REQ-026 frame_i=1 stores and size_i=3 stores -> active_o stays 0; clear_i or rst_ni low during TRACK with wr_valid_o=1 -> all outputs 0.

Source files
------------

// File: rtl/store_run_tracker.sv
// Tracks runs of contiguous non-frame stores, commits long runs to a range buffer,
// and flags a crash when a JALR follows a load from a tracked or committed range.
module store_run_tracker #(
    parameter int unsigned MIN_RUN_BYTES = 32,
    parameter int unsigned TIMEOUT       = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [1:0]  kind_i,
    input  logic [2:0]  size_i,
    input  logic        frame_i,
    input  logic [31:0] addr_i,
    input  logic        hit_i,
    input  logic        en_crash_i,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic [31:0] wr_start_o,
    output logic [31:0] wr_last_o,
    output logic        active_o,
    output logic        drop_o,
    output logic        crash_o
);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t      state_reg;
    logic [31:0] start_reg;
    logic [31:0] last_reg;
    logic [2:0]  last_size_reg;
    logic [15:0] count_reg;
    logic [3:0]  timer_reg;
    logic        armed_reg;

    logic        is_store;
    logic        tracked;
    logic        non_store;
    logic        adjacent;
    logic [16:0] count_sum;
    logic [15:0] count_sat;
    logic        close_run;
    logic        commit;
    logic        transfer;
    logic        can_load;
    logic        in_range;

    assign is_store  = valid_i && (kind_i == 2'd1);
    assign tracked   = is_store && !frame_i &&
                       ((size_i == 3'd1) || (size_i == 3'd2) || (size_i == 3'd4));
    assign non_store = valid_i && (kind_i != 2'd1);
    assign adjacent  = (addr_i == (last_reg + {29'd0, last_size_reg}));
    assign count_sum = {1'b0, count_reg} + {14'd0, size_i};
    assign count_sat = count_sum[16] ? 16'hFFFF : count_sum[15:0];

    // A run closes on a non-adjacent tracked store or when its timer has run out.
    assign close_run = (state_reg == TRACK) &&
                       ((tracked && !adjacent) || (non_store && (timer_reg == 4'd0)));
    assign commit    = close_run && (count_reg >= 16'(MIN_RUN_BYTES));
    assign transfer  = wr_valid_o && wr_ready_i;
    assign can_load  = !wr_valid_o || wr_ready_i;
    assign in_range  = (state_reg == TRACK) && (start_reg <= addr_i) && (addr_i <= last_reg);
    assign active_o  = (state_reg == TRACK);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            start_reg     <= '0;
            last_reg      <= '0;
            last_size_reg <= '0;
            count_reg     <= '0;
            timer_reg     <= '0;
            armed_reg     <= 1'b0;
            wr_valid_o    <= 1'b0;
            wr_start_o    <= '0;
            wr_last_o     <= '0;
            drop_o        <= 1'b0;
            crash_o       <= 1'b0;
        end else if (clear_i) begin
            state_reg     <= IDLE;
            start_reg     <= '0;
            last_reg      <= '0;
            last_size_reg <= '0;
            count_reg     <= '0;
            timer_reg     <= '0;
            armed_reg     <= 1'b0;
            wr_valid_o    <= 1'b0;
            wr_start_o    <= '0;
            wr_last_o     <= '0;
            drop_o        <= 1'b0;
            crash_o       <= 1'b0;
        end else begin
            crash_o <= 1'b0;

            if (transfer) begin
                wr_valid_o <= 1'b0;
            end
            // The holding register keeps its entry; a run committed behind it is lost.
            if (commit) begin
                if (can_load) begin
                    wr_valid_o <= 1'b1;
                    wr_start_o <= start_reg;
                    wr_last_o  <= last_reg;
                end else begin
                    drop_o <= 1'b1;
                end
            end

            if (tracked) begin
                if ((state_reg == TRACK) && adjacent) begin
                    last_reg      <= addr_i;
                    last_size_reg <= size_i;
                    count_reg     <= count_sat;
                    timer_reg     <= 4'(TIMEOUT);
                end else begin
                    state_reg     <= TRACK;
                    start_reg     <= addr_i;
                    last_reg      <= addr_i;
                    last_size_reg <= size_i;
                    count_reg     <= {13'd0, size_i};
                    timer_reg     <= 4'(TIMEOUT);
                end
            end else if (non_store && (state_reg == TRACK)) begin
                if (timer_reg != 4'd0) begin
                    timer_reg <= timer_reg - 4'd1;
                end else begin
                    state_reg <= IDLE;
                end
            end

            if (valid_i && (kind_i == 2'd2)) begin
                armed_reg <= hit_i || in_range;
            end
            if (valid_i && (kind_i == 2'd3)) begin
                crash_o   <= armed_reg && en_crash_i;
                armed_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_store_run_tracker.sv
// Directed and randomized checks of store_run_tracker against a run-level reference model.
module tb_store_run_tracker;

    localparam int MIN_RUN = 32;
    localparam int TMO     = 10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  kind_i = '0;
    logic [2:0]  size_i = '0;
    logic        frame_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        hit_i = 1'b0;
    logic        en_crash_i = 1'b0;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b0;
    logic [31:0] wr_start_o;
    logic [31:0] wr_last_o;
    logic        active_o;
    logic        drop_o;
    logic        crash_o;

    store_run_tracker #(.MIN_RUN_BYTES(MIN_RUN), .TIMEOUT(TMO)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .valid_i    (valid_i),
        .kind_i     (kind_i),
        .size_i     (size_i),
        .frame_i    (frame_i),
        .addr_i     (addr_i),
        .hit_i      (hit_i),
        .en_crash_i (en_crash_i),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .wr_start_o (wr_start_o),
        .wr_last_o  (wr_last_o),
        .active_o   (active_o),
        .drop_o     (drop_o),
        .crash_o    (crash_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: a run is a list summarised by its bounds, byte total and idle-op count.
    bit          m_in_run;
    logic [31:0] m_start, m_last;
    int          m_lsize, m_count, m_idle_ops;
    bit          m_armed;
    bit          m_held;
    logic [31:0] m_hstart, m_hlast;
    bit          m_drop, m_crash;
    bit          g_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_run = 0; m_start = '0; m_last = '0; m_lsize = 0; m_count = 0; m_idle_ops = 0;
        m_armed = 0; m_held = 0; m_hstart = '0; m_hlast = '0; m_drop = 0; m_crash = 0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] k, input logic [2:0] sz,
                              input logic fr, input logic [31:0] a, input logic h,
                              input logic en, input logic rdy, input logic clr);
        bit          closed_long;
        logic [31:0] c_start, c_last;
        bit          tracked;
        if (clr) begin
            model_reset();
            return;
        end
        closed_long = 0;
        c_start = m_start;
        c_last  = m_last;
        m_crash = 0;
        if (v && k == 2'd2)
            m_armed = h || (m_in_run && a >= m_start && a <= m_last);
        if (v && k == 2'd3) begin
            m_crash = m_armed && en;
            m_armed = 0;
        end
        tracked = v && k == 2'd1 && !fr && (sz == 1 || sz == 2 || sz == 4);
        if (tracked) begin
            if (m_in_run && a == m_last + 32'(m_lsize)) begin
                m_last = a; m_lsize = sz; m_count += sz; m_idle_ops = 0;
            end else begin
                if (m_in_run) closed_long = (m_count >= MIN_RUN);
                m_in_run = 1; m_start = a; m_last = a; m_lsize = sz; m_count = sz; m_idle_ops = 0;
            end
        end else if (v && k != 2'd1 && m_in_run) begin
            if (m_idle_ops == TMO) begin
                closed_long = (m_count >= MIN_RUN);
                m_in_run = 0;
            end else begin
                m_idle_ops++;
            end
        end
        if (m_held && rdy) m_held = 0;
        if (closed_long) begin
            if (m_held) m_drop = 1;
            else begin
                m_held = 1; m_hstart = c_start; m_hlast = c_last;
            end
        end
    endtask

    task automatic compare_all();
        check("active", active_o, m_in_run);
        check("wr_valid", wr_valid_o, m_held);
        if (m_held) begin
            check("wr_start", wr_start_o, m_hstart);
            check("wr_last", wr_last_o, m_hlast);
        end
        check("drop", drop_o, m_drop);
        check("crash", crash_o, m_crash);
    endtask

    task automatic step(input logic v, input logic [1:0] k, input logic [2:0] sz,
                        input logic fr, input logic [31:0] a, input logic h,
                        input logic en, input logic rdy, input logic clr);
        @(negedge clk_i);
        valid_i = v; kind_i = k; size_i = sz; frame_i = fr; addr_i = a;
        hit_i = h; en_crash_i = en; wr_ready_i = rdy; clear_i = clr;
        @(posedge clk_i);
        model_step(v, k, sz, fr, a, h, en, rdy, clr);
        #1 compare_all();
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] sz);
        step(1, 2'd1, sz, 0, a, 0, 0, g_rdy, 0);
    endtask
    task automatic other();
        step(1, 2'd0, 3'd0, 0, 32'h0, 0, 0, g_rdy, 0);
    endtask
    task automatic ld(input logic [31:0] a, input logic h);
        step(1, 2'd2, 3'd4, 0, a, h, 0, g_rdy, 0);
    endtask
    task automatic jalr(input logic en);
        step(1, 2'd3, 3'd0, 0, 32'h0, 0, en, g_rdy, 0);
    endtask
    task automatic idle_cyc();
        step(0, 2'd0, 3'd0, 0, 32'h0, 0, 0, g_rdy, 0);
    endtask
    task automatic clr();
        step(1, 2'd1, 3'd4, 0, 32'h9000, 1, 1, 1, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_active"}, active_o, 0);
        check({tag, "_wr_valid"}, wr_valid_o, 0);
        check({tag, "_wr_start"}, wr_start_o, 0);
        check({tag, "_wr_last"}, wr_last_o, 0);
        check({tag, "_drop"}, drop_o, 0);
        check({tag, "_crash"}, crash_o, 0);
    endtask

    task automatic async_reset();
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_zero_outputs("rst");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [2:0] sizes [7];
        sizes = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd3, 3'd0};
        model_reset();
        g_rdy = 1;
        repeat (2) @(posedge clk_i);
        #1 check_zero_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Nine adjacent stores then a jump commits the first run.
        for (int i = 0; i < 9; i++) st(32'h1000 + 32'(4 * i), 3'd4);
        st(32'h2000, 3'd4);
        check("req22_start", wr_start_o, 32'h1000);
        check("req22_last", wr_last_o, 32'h1020);
        idle_cyc();
        clr();

        // Timeout close: 32 bytes commit, 28 bytes do not.
        for (int i = 0; i < 8; i++) st(32'h1000 + 32'(4 * i), 3'd4);
        for (int i = 0; i < 11; i++) other();
        check("req23_commit", wr_valid_o, 1);
        idle_cyc();
        for (int i = 0; i < 7; i++) st(32'h1000 + 32'(4 * i), 3'd4);
        for (int i = 0; i < 12; i++) other();
        check("req23_short", wr_valid_o, 0);
        clr();

        // Two commits behind a stalled buffer.
        g_rdy = 0;
        for (int i = 0; i < 8; i++) st(32'h1000 + 32'(4 * i), 3'd4);
        for (int i = 0; i < 8; i++) st(32'h4000 + 32'(4 * i), 3'd4);
        st(32'h5000, 3'd4);
        idle_cyc();
        check("req24_held", wr_start_o, 32'h1000);
        check("req24_drop", drop_o, 1);
        g_rdy = 1;
        idle_cyc();
        g_rdy = 0;
        idle_cyc();
        check("req24_xfer", wr_valid_o, 0);
        g_rdy = 1;
        clr();

        // Load inside the live run arms a crash on the next JALR.
        for (int i = 0; i < 9; i++) st(32'h1000 + 32'(4 * i), 3'd4);
        ld(32'h1010, 0);
        jalr(1);
        check("req25_crash", crash_o, 1);
        other();
        ld(32'h3000, 0);
        jalr(1);
        check("req25_nocrash", crash_o, 0);
        ld(32'h3000, 1);
        jalr(0);
        clr();

        // Ignored stores, then clear and reset while holding an entry.
        step(1, 2'd1, 3'd4, 1, 32'h1000, 0, 0, 1, 0);
        st(32'h1000, 3'd3);
        check("req26_ignored", active_o, 0);
        g_rdy = 0;
        for (int i = 0; i < 8; i++) st(32'h1000 + 32'(4 * i), 3'd4);
        st(32'h6000, 3'd4);
        clr();
        check_zero_outputs("clear");
        for (int i = 0; i < 8; i++) st(32'h1000 + 32'(4 * i), 3'd4);
        st(32'h6000, 3'd4);
        async_reset();
        g_rdy = 1;

        // Randomized traffic biased towards adjacent stores.
        for (int n = 0; n < 3000; n++) begin
            logic [1:0]  k;
            logic [31:0] a;
            int          r;
            r = int'($urandom_range(0, 9));
            k = (r < 5) ? 2'd1 : (r < 7) ? 2'd0 : (r < 9) ? 2'd2 : 2'd3;
            if (m_in_run && ($urandom_range(0, 3) != 0))
                a = (k == 2'd2) ? m_start + 32'($urandom_range(0, 48)) : m_last + 32'(m_lsize);
            else
                a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 999) == 0) async_reset();
            step($urandom_range(0, 7) != 0, k, sizes[$urandom_range(0, 6)],
                 $urandom_range(0, 15) == 0, a, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
